// File: rtl/joy_serial_scan.sv
// rtl/joy_serial_scan.sv - DB15 joystick shift-chain scanner with per-frame debounce
// Loads the adapter's PISO chain, clocks 24 bits out and publishes two 12-bit button words.
module joy_serial_scan #(
  parameter int CLK_DIV  = 24,
  parameter int NBITS    = 24,
  parameter int GAP      = 16,
  parameter int DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_strobe,
  output logic        frame_stable
);

  localparam int             IW        = $clog2(NBITS);
  localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]     GAP_LAST  = 8'(GAP - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(NBITS - 1);
  localparam logic [3:0]     MATCH_MAX = 4'(DEBOUNCE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t           state_q;
  logic [7:0]       presc_q;
  logic [7:0]       tcnt_q;
  logic [IW-1:0]    idx_q;
  logic [1:0]       sync_q;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] prev_q;
  logic [3:0]       match_q;
  logic [3:0]       match_d;
  logic             tick;

  assign tick = (presc_q == DIV_LAST);

  // Free-running prescaler; DONE does not stall it, so frames may drift by up to one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? 8'd0 : presc_q + 8'd1;
    end
  end

  // Idle level is high (released buttons / unplugged adapter).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], JOY_DATA};
    end
  end

  always_comb begin
    match_d = '0;
    if (shift_q == prev_q) begin
      match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      prev_q       <= '0;
      match_q      <= '0;
      JOY_CLK      <= 1'b0;
      JOY_LOAD     <= 1'b1;
      joystick1    <= '0;
      joystick2    <= '0;
      frame_strobe <= 1'b0;
      frame_stable <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            if (tcnt_q == GAP_LAST) begin
              tcnt_q   <= '0;
              JOY_LOAD <= 1'b0;
              state_q  <= LOAD;
            end else begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end
        end
        LOAD: begin
          if (tick) begin
            if (tcnt_q == 8'd1) begin
              tcnt_q   <= '0;
              idx_q    <= '0;
              JOY_LOAD <= 1'b1;
              state_q  <= SHIFT_LO;
            end else begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            shift_q[idx_q] <= ~sync_q[1];
            JOY_CLK        <= 1'b1;
            state_q        <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            JOY_CLK <= 1'b0;
            if (idx_q == IDX_LAST) begin
              frame_strobe <= 1'b1;
              state_q      <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SHIFT_LO;
            end
          end
        end
        DONE: begin
          frame_strobe <= 1'b0;
          prev_q       <= shift_q;
          match_q      <= match_d;
          frame_stable <= (match_d == MATCH_MAX);
          if (match_d == MATCH_MAX) begin
            joystick1 <= shift_q[11:0];
            joystick2 <= shift_q[23:12];
          end
          tcnt_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_serial_scan.sv
// tb/tb_joy_serial_scan.sv - scoreboard bench for joy_serial_scan
// Two instances: default timing (DEBOUNCE=2) and fast timing (CLK_DIV=4, DEBOUNCE=1).
module tb_joy_serial_scan;

  typedef struct {
    logic [23:0] raw;
    logic [23:0] out;
    logic        stab;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance A: default parameters
  logic        a_rst_n = 1'b0;
  logic        a_data, a_jclk, a_jload, a_strobe, a_stable;
  logic [11:0] a_j1, a_j2;
  logic [23:0] a_vec = '0;
  logic [5:0]  a_cnt = '0;
  logic [23:0] a_pat_q[$];
  exp_t        a_sbq[$];
  logic [23:0] a_prev = '0;
  logic [23:0] a_out = '0;
  logic [23:0] a_last_out = '0;
  int          a_run = 1;
  int          a_frames = 0;

  joy_serial_scan u_a (
    .clk(clk), .rst_n(a_rst_n), .JOY_DATA(a_data), .JOY_CLK(a_jclk), .JOY_LOAD(a_jload),
    .joystick1(a_j1), .joystick2(a_j2), .frame_strobe(a_strobe), .frame_stable(a_stable)
  );

  assign a_data = (a_cnt < 6'd24) ? ~a_vec[a_cnt[4:0]] : 1'b1;
  always @(posedge a_jclk) a_cnt = a_cnt + 6'd1;

  // Adapter latch point: new pattern enters the chain and its expected outcome is queued.
  always @(negedge a_jload) begin
    exp_t e;
    a_vec = (a_pat_q.size() != 0) ? a_pat_q.pop_front() : 24'h0;
    a_cnt = '0;
    if (a_vec == a_prev) a_run++;
    else a_run = 1;
    a_prev = a_vec;
    e.raw  = a_vec;
    e.stab = (a_run >= 2);
    if (e.stab) a_out = a_vec;
    e.out = a_out;
    a_sbq.push_back(e);
  end

  always begin
    @(negedge clk);
    if (a_rst_n && a_strobe) begin
      exp_t e;
      check("a_hold_j1", a_j1, a_last_out[11:0]);
      check("a_hold_j2", a_j2, a_last_out[23:12]);
      @(negedge clk);
      check("a_sb_avail", 32'(a_sbq.size() != 0), 1);
      if (a_sbq.size() != 0) begin
        e = a_sbq.pop_front();
        check("a_j1", a_j1, e.out[11:0]);
        check("a_j2", a_j2, e.out[23:12]);
        check("a_stable", a_stable, e.stab);
        check("a_strobe_1clk", a_strobe, 0);
        a_last_out = e.out;
      end
      a_frames++;
    end
  end

  // Instance B: fast timing, no debounce
  logic        b_rst_n = 1'b0;
  logic        b_data, b_jclk, b_jload, b_strobe, b_stable;
  logic [11:0] b_j1, b_j2;
  logic [23:0] b_vec = '0;
  logic [5:0]  b_cnt = '0;
  exp_t        b_sbq[$];
  int          b_frames = 0;

  joy_serial_scan #(.CLK_DIV(4), .NBITS(24), .GAP(4), .DEBOUNCE(1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .JOY_DATA(b_data), .JOY_CLK(b_jclk), .JOY_LOAD(b_jload),
    .joystick1(b_j1), .joystick2(b_j2), .frame_strobe(b_strobe), .frame_stable(b_stable)
  );

  assign b_data = (b_cnt < 6'd24) ? ~b_vec[b_cnt[4:0]] : 1'b1;
  always @(posedge b_jclk) b_cnt = b_cnt + 6'd1;

  always @(negedge b_jload) begin
    exp_t e;
    b_vec  = 24'($urandom);
    b_cnt  = '0;
    e.raw  = b_vec;
    e.out  = b_vec;
    e.stab = 1'b1;
    b_sbq.push_back(e);
  end

  always begin
    @(negedge clk);
    if (b_rst_n && b_strobe) begin
      exp_t e;
      @(negedge clk);
      check("b_sb_avail", 32'(b_sbq.size() != 0), 1);
      if (b_sbq.size() != 0) begin
        e = b_sbq.pop_front();
        check("b_j1", b_j1, e.out[11:0]);
        check("b_j2", b_j2, e.out[23:12]);
        check("b_stable", b_stable, e.stab);
      end
      b_frames++;
    end
  end

  task automatic wait_frames_a(input int n);
    int k = 0;
    while (a_frames < n && k < 40000) begin
      @(negedge clk);
      k++;
    end
    check("a_frames_reached", 32'(a_frames >= n), 1);
  endtask

  task automatic load_latency_a();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (a_jload && k < 2000);
    check("a_load_latency", k, 384);
  endtask

  initial begin
    a_pat_q = '{24'h0, 24'h0, 24'h010001, 24'h010001, 24'h010001};
    repeat (3) @(negedge clk);
    check("rst_jclk", a_jclk, 0);
    check("rst_jload", a_jload, 1);
    check("rst_j1", a_j1, 0);
    check("rst_j2", a_j2, 0);
    check("rst_strobe", a_strobe, 0);
    check("rst_stable", a_stable, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    fork
      begin
        int k, p, pulses, hi, hmin, hmax;
        load_latency_a();
        k = 0;
        while (!a_jload && k < 200) begin
          @(negedge clk);
          k++;
        end
        check("a_load_low_clks", k, 48);
        p = 48; pulses = 0; hi = 0; hmin = 9999; hmax = 0;
        while (a_jload && p < 3000) begin
          @(negedge clk);
          p++;
          if (a_jclk) begin
            if (hi == 0) pulses++;
            hi++;
          end else if (hi != 0) begin
            if (hi < hmin) hmin = hi;
            if (hi > hmax) hmax = hi;
            hi = 0;
          end
        end
        check("a_jclk_pulses", pulses, 24);
        check("a_jclk_hi_min", hmin, 24);
        check("a_jclk_hi_max", hmax, 24);
        check("a_period_window", 32'(p >= 1584 && p <= 1608), 1);

        wait_frames_a(4);
        check("a_pattern_j1", a_j1, 12'h001);
        check("a_pattern_j2", a_j2, 12'h010);
        check("a_pattern_stable", a_stable, 1);

        // Abort frame 5 mid-shift around bit 10
        k = 0;
        while (a_jload && k < 3000) begin @(negedge clk); k++; end
        while (!a_jload && k < 3000) begin @(negedge clk); k++; end
        pulses = 0; hi = 0;
        while (pulses < 10 && k < 3000) begin
          @(negedge clk);
          k++;
          if (a_jclk && hi == 0) pulses++;
          hi = a_jclk ? 1 : 0;
        end
        while (a_jclk && k < 3000) begin @(negedge clk); k++; end
        check("a_reached_bit10", 32'(k < 3000), 1);
        repeat (5) @(negedge clk);
        a_rst_n = 1'b0;
        #1;
        check("midrst_jclk", a_jclk, 0);
        check("midrst_jload", a_jload, 1);
        check("midrst_j1", a_j1, 0);
        check("midrst_j2", a_j2, 0);
        check("midrst_stable", a_stable, 0);
        a_sbq.delete();
        a_pat_q = '{24'h0, 24'h0, 24'h8, 24'h0, 24'h0, 24'hF, 24'h0, 24'hF, 24'h0,
                    24'hF, 24'hF, 24'hF};
        a_prev = '0; a_out = '0; a_last_out = '0; a_run = 1; a_frames = 0;
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1;
        load_latency_a();

        wait_frames_a(12);
        check("a_final_j1", a_j1, 12'h00F);
        check("a_final_j2", a_j2, 12'h000);
        check("a_final_stable", a_stable, 1);
      end
      begin
        int k = 0;
        while (!b_jclk && k < 1000) begin @(negedge clk); k++; end
        k = 0;
        while (b_jclk && k < 100) begin @(negedge clk); k++; end
        check("b_jclk_half", k, 4);
      end
    join

    check("b_frames_seen", 32'(b_frames >= 10), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
